mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between instruction fetch (IF) and load/store (MEM) in the 5-stage pipelined core.
- Sequences each access as a request/response transaction on the memory port.
- Returns fetch data and load data to the pipeline.
- Drives stall requests that the hazard unit ORs into StallF/StallD/StallE/StallM.

Parameters:
- XLEN, 32, data width and address width.
- STRB_W, XLEN/8, byte-strobe width.

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous reset, active-low
- imem_req  in  1  IF wants an instruction; held high until imem_valid
- imem_addr  in  XLEN  fetch PC
- imem_rdata  out  XLEN  fetched instruction
- imem_valid  out  1  one-cycle pulse, imem_rdata valid
- fetch_kill  in  1  branch-taken flush (PCSrcE); discards any fetch in flight
- dmem_req  in  1  MEM wants a load/store; held high with stable fields until dmem_done
- dmem_we  in  1  1 = store
- dmem_addr  in  XLEN  data address
- dmem_wdata  in  XLEN  store data
- dmem_wstrb  in  STRB_W  store byte enables
- dmem_rdata  out  XLEN  load data
- dmem_done  out  1  one-cycle pulse, transaction complete
- mem_req_valid  out  1  request valid to memory
- mem_req_ready  in  1  memory accepts the request
- mem_we  out  1  write enable to memory
- mem_addr  out  XLEN  address to memory
- mem_wdata  out  XLEN  write data to memory
- mem_wstrb  out  STRB_W  byte strobes to memory
- mem_resp_valid  in  1  response valid; exactly one per accepted request, stores included
- mem_rdata  in  XLEN  response data
- stall_fetch  out  1  imem_req & ~imem_valid
- stall_mem  out  1  dmem_req & ~dmem_done
- busy  out  1  state != IDLE

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE; drop flag cleared; every registered output 0 (mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb, imem_valid, imem_rdata, dmem_done, dmem_rdata).
- Reset mid-transaction: abandon it and return to IDLE. The memory shares rst_n, so no stale response arrives.
- FSM states: IDLE, I_REQ, I_WAIT, D_REQ, D_WAIT. Only one transaction outstanding at any time.
- IDLE:
  - dmem_req high: latch dmem fields into the request registers, go to D_REQ.
  - else imem_req high: latch imem_addr (mem_we=0, mem_wstrb=0), go to I_REQ.
  - Data has fixed priority: the MEM instruction is older.
- I_REQ / D_REQ:
  - mem_req_valid=1 with latched fields held stable.
  - On mem_req_ready go to I_WAIT / D_WAIT and drop mem_req_valid.
  - Valid is never withdrawn before ready, including under fetch_kill.
- I_WAIT / D_WAIT: wait for mem_resp_valid, then go to IDLE.
- Completion from I_WAIT:
  - Next cycle: imem_rdata <= mem_rdata and imem_valid pulses, unless the drop flag is set.
  - If drop is set, the response is consumed silently and drop is cleared.
- Completion from D_WAIT: next cycle, dmem_rdata <= mem_rdata (stores too; the value is don't-care) and dmem_done pulses.
- IDLE may re-arbitrate in the same cycle the done/valid pulse is driven. The requester must drop req on the pulse cycle; a req still high at the next edge is treated as a new request.
- Minimum latency, memory with ready=1 and 1-cycle response: req seen at cycle 0 (IDLE), REQ at cycle 1, resp in WAIT at cycle 2, pulse at cycle 3.
- fetch_kill:
  - In I_REQ or I_WAIT: set drop.
  - In the completion cycle (resp this cycle): the pulse is also suppressed.
  - In IDLE or D_*: no effect.
  - fetch_kill and imem_req may both be high; the new PC is fetched after the dropped one completes.
- stall_fetch and stall_mem are purely combinational from req and pulse.
- busy is combinational from state.
- mem_resp_valid outside a WAIT state is a protocol error: flag it with an assertion and ignore it.
- dmem_req falling before dmem_done is illegal: flag it with an assertion.

Decomposition:
- Shared package core_pkg holds:
  - the arb_state_t enum (IDLE, I_REQ, I_WAIT, D_REQ, D_WAIT);
  - a mem_req_t struct {we, addr, wdata, wstrb}.
- Single module; no sub-module needed.
- Request register and FSM live in one sequential block; next-state and stalls in one combinational block.

Test Plan:
- Single fetch: imem_req addr 0x0000_0010, ready=1, resp 0x00A0_0093 one cycle later -> imem_valid at cycle 3 with rdata 0x00A0_0093; stall_fetch high cycles 0-2.
- Both requesting: imem_req and dmem_req (load 0x100) together -> D_REQ first with mem_addr=0x100; fetch issued only after dmem_done; imem_valid follows.
- Backpressure: store 0x200, wdata 0xDEAD_BEEF, wstrb 0xF, ready low for 4 cycles -> mem_req_valid held 5 cycles with fields stable; dmem_done pulses once after resp.
- Kill in flight: fetch 0x40, fetch_kill pulsed during I_WAIT, resp 0x1234 -> no imem_valid; next fetch 0x80 returns normally.
- Kill on response cycle: fetch_kill coincides with mem_resp_valid -> pulse suppressed, FSM returns to IDLE.
- Reset mid-op: rst_n low during D_WAIT -> next cycle IDLE, all outputs 0, busy=0; a new load then completes normally.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types for the memory-port arbiter: FSM state encoding and the
// latched memory request fields.
package core_pkg;

  localparam int CORE_XLEN   = 32;
  localparam int CORE_STRB_W = CORE_XLEN / 8;

  typedef enum logic [2:0] {
    IDLE,
    I_REQ,
    I_WAIT,
    D_REQ,
    D_WAIT
  } arb_state_t;

  typedef struct packed {
    logic                   we;
    logic [CORE_XLEN-1:0]   addr;
    logic [CORE_XLEN-1:0]   wdata;
    logic [CORE_STRB_W-1:0] wstrb;
  } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and load/store,
// one transaction outstanding at a time, data side having fixed priority.
module mem_port_arbiter
  import core_pkg::*;
#(
  parameter int XLEN   = CORE_XLEN,
  parameter int STRB_W = XLEN / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              imem_req,
  input  logic [XLEN-1:0]   imem_addr,
  output logic [XLEN-1:0]   imem_rdata,
  output logic              imem_valid,
  input  logic              fetch_kill,
  input  logic              dmem_req,
  input  logic              dmem_we,
  input  logic [XLEN-1:0]   dmem_addr,
  input  logic [XLEN-1:0]   dmem_wdata,
  input  logic [STRB_W-1:0] dmem_wstrb,
  output logic [XLEN-1:0]   dmem_rdata,
  output logic              dmem_done,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [STRB_W-1:0] mem_wstrb,
  input  logic              mem_resp_valid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              stall_fetch,
  output logic              stall_mem,
  output logic              busy
);

  // Memory handshake: a request transfers on a clk edge where mem_req_valid and
  // mem_req_ready are both high; valid and the request fields stay stable until
  // then. Exactly one mem_resp_valid cycle follows each transferred request.

  arb_state_t state, state_next;
  mem_req_t   req_q;
  logic       drop;

  assign mem_we    = req_q.we;
  assign mem_addr  = req_q.addr;
  assign mem_wdata = req_q.wdata;
  assign mem_wstrb = req_q.wstrb;

  always_comb begin
    state_next  = state;
    stall_fetch = imem_req & ~imem_valid;
    stall_mem   = dmem_req & ~dmem_done;
    busy        = (state != IDLE);
    case (state)
      IDLE: begin
        if (dmem_req)      state_next = D_REQ;
        else if (imem_req) state_next = I_REQ;
      end
      I_REQ:   if (mem_req_ready)  state_next = I_WAIT;
      I_WAIT:  if (mem_resp_valid) state_next = IDLE;
      D_REQ:   if (mem_req_ready)  state_next = D_WAIT;
      D_WAIT:  if (mem_resp_valid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      drop          <= 1'b0;
      req_q         <= '0;
      mem_req_valid <= 1'b0;
      imem_valid    <= 1'b0;
      imem_rdata    <= '0;
      dmem_done     <= 1'b0;
      dmem_rdata    <= '0;
    end else begin
      state         <= state_next;
      mem_req_valid <= (state_next == I_REQ) || (state_next == D_REQ);
      imem_valid    <= 1'b0;
      dmem_done     <= 1'b0;
      case (state)
        IDLE: begin
          if (dmem_req) begin
            req_q.we    <= dmem_we;
            req_q.addr  <= dmem_addr;
            req_q.wdata <= dmem_wdata;
            req_q.wstrb <= dmem_wstrb;
          end else if (imem_req) begin
            req_q.we    <= 1'b0;
            req_q.addr  <= imem_addr;
            req_q.wdata <= '0;
            req_q.wstrb <= '0;
          end
        end
        I_REQ: begin
          if (fetch_kill) drop <= 1'b1;
        end
        I_WAIT: begin
          // A kill arriving with the response suppresses the pulse directly.
          if (mem_resp_valid) begin
            if (!(drop || fetch_kill)) begin
              imem_valid <= 1'b1;
              imem_rdata <= mem_rdata;
            end
            drop <= 1'b0;
          end else if (fetch_kill) begin
            drop <= 1'b1;
          end
        end
        D_WAIT: begin
          if (mem_resp_valid) begin
            dmem_done  <= 1'b1;
            dmem_rdata <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  a_resp_in_wait: assert property (@(posedge clk) disable iff (!rst_n)
    mem_resp_valid |-> (state == I_WAIT || state == D_WAIT));

  a_dmem_req_held: assert property (@(posedge clk) disable iff (!rst_n)
    (dmem_req && !dmem_done) |=> (dmem_req || dmem_done));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int W  = 32;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          imem_req = 1'b0;
  logic [W-1:0]  imem_addr = '0;
  logic [W-1:0]  imem_rdata;
  logic          imem_valid;
  logic          fetch_kill = 1'b0;
  logic          dmem_req = 1'b0;
  logic          dmem_we = 1'b0;
  logic [W-1:0]  dmem_addr = '0;
  logic [W-1:0]  dmem_wdata = '0;
  logic [SW-1:0] dmem_wstrb = '0;
  logic [W-1:0]  dmem_rdata;
  logic          dmem_done;
  logic          mem_req_valid;
  logic          mem_req_ready = 1'b1;
  logic          mem_we;
  logic [W-1:0]  mem_addr;
  logic [W-1:0]  mem_wdata;
  logic [SW-1:0] mem_wstrb;
  logic          mem_resp_valid = 1'b0;
  logic [W-1:0]  mem_rdata = '0;
  logic          stall_fetch;
  logic          stall_mem;
  logic          busy;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_valid(imem_valid), .fetch_kill(fetch_kill),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_rdata(dmem_rdata),
    .dmem_done(dmem_done),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
    .stall_fetch(stall_fetch), .stall_mem(stall_mem), .busy(busy)
  );

  // ---------------- check bookkeeping ----------------
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=event required=none t=%0t", name, $time);
  endtask

  // ---------------- memory responder ----------------
  bit           rand_on = 1'b0;
  int           hold = 0;
  int           resp_dly = 1;
  int           cd = 0;
  logic [W-1:0] dir_data_q[$];

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      cd = 0;
      mem_resp_valid = 1'b0;
      mem_req_ready = 1'b1;
    end else begin
      mem_resp_valid = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          mem_resp_valid = 1'b1;
          if (dir_data_q.size() > 0) mem_rdata = dir_data_q.pop_front();
          else                       mem_rdata = $urandom();
        end
      end
      if (rand_on) begin
        mem_req_ready = ($urandom_range(0, 2) != 0);
      end else begin
        mem_req_ready = (hold == 0);
        if (mem_req_valid && hold > 0) hold--;
      end
      if (mem_req_valid && mem_req_ready) begin
        if (rand_on) cd = $urandom_range(1, 3);
        else         cd = resp_dly;
      end
    end
  end

  // ---------------- requester drivers ----------------
  initial forever begin
    @(negedge clk);
    if (imem_valid) imem_req = 1'b0;
    else if (rand_on && !imem_req && $urandom_range(0, 2) == 0) begin
      imem_req  = 1'b1;
      imem_addr = $urandom() & 32'hFFFF_FFFC;
    end
    if (dmem_done) dmem_req = 1'b0;
    else if (rand_on && !dmem_req && $urandom_range(0, 3) == 0) begin
      dmem_req   = 1'b1;
      dmem_we    = 1'($urandom_range(0, 1));
      dmem_addr  = $urandom() & 32'hFFFF_FFFC;
      dmem_wdata = $urandom();
      dmem_wstrb = 4'($urandom_range(0, 15));
    end
    if (rand_on) begin
      fetch_kill = ($urandom_range(0, 11) == 0);
      if (fetch_kill && imem_req) imem_addr = $urandom() & 32'hFFFF_FFFC;
    end
  end

  // ---------------- transaction-level model ----------------
  // owner: 0 none, 1 fetch, 2 data. A transaction is issued (sent) once the
  // memory accepts it and completes on its single response.
  int            owner = 0;
  bit            sent = 1'b0;
  bit            drop_m = 1'b0;
  bit            in_rst = 1'b1;
  logic          e_we = 1'b0;
  logic [W-1:0]  e_addr = '0;
  logic [W-1:0]  e_wdata = '0;
  logic [SW-1:0] e_wstrb = '0;
  bit            e_iv = 1'b0;
  bit            e_dd = 1'b0;
  logic [W-1:0]  e_ird = '0;
  logic [W-1:0]  e_drd = '0;
  logic [W-1:0]  exp_q[$];

  initial forever begin
    @(posedge clk);
    e_iv = 1'b0;
    e_dd = 1'b0;
    in_rst = !rst_n;
    if (!rst_n) begin
      owner = 0; sent = 1'b0; drop_m = 1'b0;
      e_we = 1'b0; e_addr = '0; e_wdata = '0; e_wstrb = '0;
      e_ird = '0; e_drd = '0;
      exp_q.delete();
    end else if (owner == 0) begin
      if (dmem_req) begin
        owner = 2; sent = 1'b0;
        e_we = dmem_we; e_addr = dmem_addr; e_wdata = dmem_wdata; e_wstrb = dmem_wstrb;
      end else if (imem_req) begin
        owner = 1; sent = 1'b0;
        e_we = 1'b0; e_addr = imem_addr; e_wstrb = '0;
      end
    end else if (!sent) begin
      if (owner == 1 && fetch_kill) drop_m = 1'b1;
      if (mem_req_ready) sent = 1'b1;
    end else if (mem_resp_valid) begin
      if (owner == 1) begin
        if (!drop_m && !fetch_kill) begin
          e_iv = 1'b1; e_ird = mem_rdata; exp_q.push_back(mem_rdata);
        end
        drop_m = 1'b0;
      end else begin
        e_dd = 1'b1; e_drd = mem_rdata; exp_q.push_back(mem_rdata);
      end
      owner = 0;
    end else if (owner == 1 && fetch_kill) begin
      drop_m = 1'b1;
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(posedge clk);
    #1;
    chk1("mem_req_valid", mem_req_valid, (owner != 0) && !sent);
    if (in_rst || (owner != 0 && !sent)) begin
      chk("mem_addr", mem_addr, e_addr);
      chk1("mem_we", mem_we, e_we);
      chk({28'b0, mem_wstrb} == 32'(0) ? "mem_wstrb" : "mem_wstrb", {28'b0, mem_wstrb}, {28'b0, e_wstrb});
      if (in_rst || e_we) chk("mem_wdata", mem_wdata, e_wdata);
    end
    chk1("imem_valid", imem_valid, e_iv);
    chk1("dmem_done", dmem_done, e_dd);
    chk1("busy", busy, owner != 0);
    chk1("stall_fetch", stall_fetch, imem_req & ~e_iv);
    chk1("stall_mem", stall_mem, dmem_req & ~e_dd);
    chk("imem_rdata", imem_rdata, e_ird);
    chk("dmem_rdata", dmem_rdata, e_drd);
    if (imem_valid || dmem_done) begin
      if (exp_q.size() == 0) fail_now("sb_unexpected_pulse");
      else if (imem_valid)   chk("sb_imem_data", imem_rdata, exp_q.pop_front());
      else                   chk("sb_dmem_data", dmem_rdata, exp_q.pop_front());
    end
  end

  // ---------------- directed helpers ----------------
  task automatic wait_pulse(input bit is_fetch, input int max, output int n);
    n = 0;
    while (n < max) begin
      @(negedge clk);
      n++;
      if (is_fetch ? imem_valid : dmem_done) return;
    end
    fail_now(is_fetch ? "timeout_imem_valid" : "timeout_dmem_done");
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int vcnt;
    int dcnt;
    int bad;
    int k;

    settle(3);
    chk1("reset_busy", busy, 1'b0);
    chk1("reset_mem_req_valid", mem_req_valid, 1'b0);
    chk("reset_imem_rdata", imem_rdata, 32'h0);
    rst_n = 1'b1;
    settle(2);

    // single fetch, minimum latency
    dir_data_q.push_back(32'h00A0_0093);
    resp_dly = 1;
    @(negedge clk);
    imem_req = 1'b1; imem_addr = 32'h0000_0010;
    #1 chk1("t1_stall_c0", stall_fetch, 1'b1);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c < 3) begin
        chk1("t1_stall_mid", stall_fetch, 1'b1);
        chk1("t1_no_valid_yet", imem_valid, 1'b0);
      end else begin
        chk1("t1_valid_c3", imem_valid, 1'b1);
        chk("t1_rdata", imem_rdata, 32'h00A0_0093);
      end
    end
    settle(2);

    // simultaneous fetch and load: load wins
    dir_data_q.push_back(32'h1111_1111);
    dir_data_q.push_back(32'h2222_2222);
    @(negedge clk);
    imem_req = 1'b1; imem_addr = 32'h0000_0020;
    dmem_req = 1'b1; dmem_we = 1'b0; dmem_addr = 32'h0000_0100;
    @(negedge clk);
    chk1("t2_req_valid", mem_req_valid, 1'b1);
    chk("t2_addr_is_load", mem_addr, 32'h0000_0100);
    chk1("t2_we", mem_we, 1'b0);
    wait_pulse(1'b0, 10, n);
    chk("t2_load_lat", n, 2);
    chk("t2_load_data", dmem_rdata, 32'h1111_1111);
    chk1("t2_fetch_after", imem_valid, 1'b0);
    wait_pulse(1'b1, 10, n);
    chk("t2_fetch_lat", n, 3);
    chk("t2_fetch_data", imem_rdata, 32'h2222_2222);
    settle(2);

    // store under backpressure
    hold = 4;
    dir_data_q.push_back(32'h0);
    @(negedge clk);
    dmem_req = 1'b1; dmem_we = 1'b1; dmem_addr = 32'h0000_0200;
    dmem_wdata = 32'hDEAD_BEEF; dmem_wstrb = 4'hF;
    vcnt = 0; dcnt = 0; bad = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (mem_req_valid) begin
        vcnt++;
        if (mem_addr !== 32'h200 || mem_wdata !== 32'hDEAD_BEEF ||
            mem_wstrb !== 4'hF || mem_we !== 1'b1) bad++;
      end
      if (dmem_done) dcnt++;
    end
    chk("t3_valid_cycles", vcnt, 5);
    chk("t3_field_changes", bad, 0);
    chk("t3_done_pulses", dcnt, 1);
    settle(1);

    // kill while waiting for the response; the new PC is fetched afterwards
    dir_data_q.push_back(32'h0000_1234);
    dir_data_q.push_back(32'h0000_5678);
    resp_dly = 3;
    @(negedge clk);
    imem_req = 1'b1; imem_addr = 32'h0000_0040;
    settle(2);
    fetch_kill = 1'b1; imem_addr = 32'h0000_0080;
    @(negedge clk);
    fetch_kill = 1'b0;
    wait_pulse(1'b1, 20, n);
    chk("t4_refetch_lat", n, 7);
    chk("t4_refetch_data", imem_rdata, 32'h0000_5678);
    settle(2);

    // kill coinciding with the response
    dir_data_q.push_back(32'hBAD0_BAD0);
    resp_dly = 1;
    @(negedge clk);
    imem_req = 1'b1; imem_addr = 32'h0000_00C0;
    settle(1);
    @(negedge clk);
    fetch_kill = 1'b1; imem_req = 1'b0;
    @(negedge clk);
    fetch_kill = 1'b0;
    chk1("t5_no_pulse", imem_valid, 1'b0);
    chk1("t5_idle", busy, 1'b0);
    settle(2);
    dir_data_q.push_back(32'h0BAD_F00D);
    @(negedge clk);
    imem_req = 1'b1; imem_addr = 32'h0000_0044;
    wait_pulse(1'b1, 10, n);
    chk("t5_next_lat", n, 3);
    chk("t5_next_data", imem_rdata, 32'h0BAD_F00D);
    settle(2);

    // reset in D_WAIT; the held request becomes a fresh load afterwards
    resp_dly = 3;
    @(negedge clk);
    dmem_req = 1'b1; dmem_we = 1'b0; dmem_addr = 32'h0000_0300;
    settle(2);
    rst_n = 1'b0;
    @(negedge clk);
    chk1("t6_busy", busy, 1'b0);
    chk1("t6_req_valid", mem_req_valid, 1'b0);
    chk("t6_mem_addr", mem_addr, 32'h0);
    chk1("t6_done", dmem_done, 1'b0);
    chk("t6_dmem_rdata", dmem_rdata, 32'h0);
    dmem_addr = 32'h0000_0304;
    dir_data_q.push_back(32'h0000_CAFE);
    resp_dly = 1;
    @(negedge clk);
    rst_n = 1'b1;
    wait_pulse(1'b0, 10, n);
    chk("t6_load_lat", n, 3);
    chk("t6_load_data", dmem_rdata, 32'h0000_CAFE);
    settle(2);

    // randomized traffic
    rand_on = 1'b1;
    settle(3000);
    rand_on = 1'b0;
    fetch_kill = 1'b0;
    k = 0;
    while ((imem_req || dmem_req || busy) && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) fail_now("drain_timeout");
    settle(3);
    chk("sb_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    fail_now("global_timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
